// File: rtl/seq_mul.sv
// seq_mul: iterative MUL/MULH/MULHSU/MULHU unit retiring STEP multiplier bits per cycle.
module seq_mul #(
  parameter int WIDTH = 32,
  parameter int STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int N = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state_q;
  logic [2:0] op_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, result_q, sel;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [CW-1:0] cnt_q;
  logic neg_q, s1, s2;
  logic [WIDTH+STEP-1:0] pp;
  logic [2*WIDTH+STEP-1:0] sum;
  assign s1 = ~op[2] & (op[1:0] == 2'b01 | op[1:0] == 2'b10) & op1[WIDTH-1];
  assign s2 = op == 3'b001 & op2[WIDTH-1];
  always_comb begin
    pp = '0;
    for (int i = 0; i < STEP; i++) pp = pp + (mplier_q[i] ? {{STEP{1'b0}}, mcand_q} << i : '0);
  end
  // Right-shifting accumulator: partial products enter at the top half.
  assign sum = {{STEP{1'b0}}, acc_q} + {pp, {WIDTH{1'b0}}};
  assign acc_d = (2*WIDTH)'(sum >> STEP);
  assign prod = neg_q ? -acc_q : acc_q;
  assign sel = op_q[2] ? '0 : op_q[1:0] == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      neg_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      result_q <= '0;
    end else
      case (state_q)
        IDLE: if (in_valid) begin
          state_q <= RUN;
          op_q <= op;
          mcand_q <= s1 ? -op1 : op1;
          mplier_q <= s2 ? -op2 : op2;
          neg_q <= s1 ^ s2;
          acc_q <= '0;
          cnt_q <= '0;
        end
        RUN: if (abort) state_q <= IDLE;
          else if (cnt_q == CW'(N)) state_q <= FIX;
          else begin
            acc_q <= acc_d;
            mplier_q <= mplier_q >> STEP;
            cnt_q <= cnt_q + CW'(1);
          end
        FIX: begin
          state_q <= abort ? IDLE : DONE;
          if (!abort) result_q <= sel;
        end
        DONE: if (abort || out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
  assign in_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign result = result_q;
endmodule
